// File: rtl/demux_1to2_reg_if.sv
// Handshake bundle for demux_1to2_reg: one input stream and two registered output channels.
// The master modport is the environment side and the slave modport is the demux side.
interface demux_1to2_reg_if #(
  parameter int width = 2
);
  logic [width-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [width-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [width-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;

  modport master (
    output in_data, in_sel, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid
  );
endinterface

// File: rtl/demux_1to2_reg.sv
// Registered 1-to-2 demultiplexer with a one-entry output register per channel.
// Optional macro DEMUX_STATS_EN adds per-channel completed-transfer counters cnt0/cnt1.
module demux_1to2_reg #(
  parameter int width = 2,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef DEMUX_STATS_EN
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
`endif
  demux_1to2_reg_if.slave   bus
);

  logic [width-1:0] data0_q, data1_q;
  logic             valid0_q, valid1_q;
  logic             can_load0, can_load1;
  logic             accept, accept0, accept1;

  // A channel can take a new word when empty or when its current word leaves this cycle.
  assign can_load0 = !valid0_q || bus.out0_ready;
  assign can_load1 = !valid1_q || bus.out1_ready;

  assign bus.in_ready = bus.in_sel ? can_load1 : can_load0;
  assign accept       = bus.in_valid && bus.in_ready;
  assign accept0      = accept && !bus.in_sel;
  assign accept1      = accept &&  bus.in_sel;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data0_q  <= '0;
      data1_q  <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
    end else begin
      if (accept0) begin
        data0_q  <= bus.in_data;
        valid0_q <= 1'b1;
      end else if (bus.out0_ready) begin
        valid0_q <= 1'b0;
      end

      if (accept1) begin
        data1_q  <= bus.in_data;
        valid1_q <= 1'b1;
      end else if (bus.out1_ready) begin
        valid1_q <= 1'b0;
      end
    end
  end

  assign bus.out0_data  = data0_q;
  assign bus.out0_valid = valid0_q;
  assign bus.out1_data  = data1_q;
  assign bus.out1_valid = valid1_q;

`ifdef DEMUX_STATS_EN
  // Counters wrap freely; only rst_n clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (valid0_q && bus.out0_ready) cnt0 <= cnt0 + 1'b1;
      if (valid1_q && bus.out1_ready) cnt1 <= cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_1to2_reg.sv
// Directed self-checking bench for demux_1to2_reg (width=2; CNT_W=2 when DEMUX_STATS_EN is set).
`timescale 1ns/1ps
module tb_demux_1to2_reg;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  demux_1to2_reg_if #(.width(2)) bus ();

`ifdef DEMUX_STATS_EN
  logic [1:0] cnt0, cnt1;
  demux_1to2_reg #(.width(2), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt0  (cnt0),
    .cnt1  (cnt1),
    .bus   (bus)
  );
`else
  demux_1to2_reg #(.width(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Drive one input beat half a cycle before the active edge.
  task automatic drive(input logic v, input logic s, input logic [1:0] d);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_sel   = s;
    bus.in_data  = d;
  endtask

  task automatic edge_then_settle();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] stream [8];

  initial begin
    stream = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_sel     = 1'b0;
    bus.in_data    = 2'b00;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;

    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    edge_then_settle();
    check("rst_out0_valid", 32'(bus.out0_valid), 32'd0);
    check("rst_out1_valid", 32'(bus.out1_valid), 32'd0);
    check("rst_out0_data",  32'(bus.out0_data),  32'd0);
    check("rst_out1_data",  32'(bus.out1_data),  32'd0);
    check("rst_in_ready",   32'(bus.in_ready),   32'd1);
`ifdef DEMUX_STATS_EN
    check("rst_cnt0", 32'(cnt0), 32'd0);
    check("rst_cnt1", 32'(cnt1), 32'd0);
`endif

    // Basic steer
    drive(1'b1, 1'b0, 2'b10);
    #1 check("steer_in_ready0", 32'(bus.in_ready), 32'd1);
    edge_then_settle();
    check("steer_out0_valid", 32'(bus.out0_valid), 32'd1);
    check("steer_out0_data",  32'(bus.out0_data),  32'd2);
    drive(1'b1, 1'b1, 2'b11);
    edge_then_settle();
    check("steer_out1_valid", 32'(bus.out1_valid), 32'd1);
    check("steer_out1_data",  32'(bus.out1_data),  32'd3);
    check("steer_out0_drain", 32'(bus.out0_valid), 32'd0);
    drive(1'b0, 1'b0, 2'b00);
    edge_then_settle();
    check("steer_out1_drain", 32'(bus.out1_valid), 32'd0);

    // Stall isolation
    @(negedge clk);
    bus.out0_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_data = 2'b01;
    edge_then_settle();
    check("stall_first_valid", 32'(bus.out0_valid), 32'd1);
    check("stall_first_data",  32'(bus.out0_data),  32'd1);
    drive(1'b1, 1'b0, 2'b10);
    #1 check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    edge_then_settle();
    check("stall_hold_data",  32'(bus.out0_data),  32'd1);
    check("stall_hold_valid", 32'(bus.out0_valid), 32'd1);
    drive(1'b1, 1'b1, 2'b11);
    #1 check("stall_other_ready", 32'(bus.in_ready), 32'd1);
    edge_then_settle();
    check("stall_other_data",  32'(bus.out1_data),  32'd3);
    check("stall_other_valid", 32'(bus.out1_valid), 32'd1);
    check("stall_still_held",  32'(bus.out0_data),  32'd1);
    @(negedge clk);
    bus.out0_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_data = 2'b10;
    #1 check("release_in_ready", 32'(bus.in_ready), 32'd1);
    edge_then_settle();
    check("release_data",      32'(bus.out0_data),  32'd2);
    check("release_valid",     32'(bus.out0_valid), 32'd1);
    check("release_out1_gone", 32'(bus.out1_valid), 32'd0);
    drive(1'b0, 1'b0, 2'b00);
    edge_then_settle();
    check("release_drained", 32'(bus.out0_valid), 32'd0);

    // Full-rate stream on channel 1
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, stream[i]);
      #1 check($sformatf("stream_ready_%0d", i), 32'(bus.in_ready), 32'd1);
      edge_then_settle();
      check($sformatf("stream_data_%0d", i),  32'(bus.out1_data),  32'(stream[i]));
      check($sformatf("stream_valid_%0d", i), 32'(bus.out1_valid), 32'd1);
    end
    drive(1'b0, 1'b0, 2'b00);
    edge_then_settle();
    check("stream_drained", 32'(bus.out1_valid), 32'd0);

    // Async reset mid-operation
    @(negedge clk);
    bus.out0_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_data = 2'b11;
    edge_then_settle();
    check("areset_pre_valid", 32'(bus.out0_valid), 32'd1);
    check("areset_pre_data",  32'(bus.out0_data),  32'd3);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("areset_now_valid", 32'(bus.out0_valid), 32'd0);
    check("areset_now_data",  32'(bus.out0_data),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out0_ready = 1'b1;
    edge_then_settle();
    check("areset_after_valid", 32'(bus.out0_valid), 32'd0);

`ifdef DEMUX_STATS_EN
    // Five channel-0 handshakes with a 2-bit counter wrap to 1
    check("stats_clr_cnt0", 32'(cnt0), 32'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 2'(i));
      edge_then_settle();
    end
    drive(1'b0, 1'b0, 2'b00);
    edge_then_settle();
    check("stats_cnt0_wrap", 32'(cnt0), 32'd1);
    check("stats_cnt1_zero", 32'(cnt1), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/demux_1to2_reg.md
Name: demux_1to2_reg

Overview:
- Registered 1-to-2 demultiplexer: the inverse of the team's 2:1 mux, on a valid/ready handshake.
- Accepts one word per cycle on a single input stream and steers it to output channel 0 or 1 based on in_sel.
- Each channel has a one-entry output register with its own valid/ready handshake, so a stalled channel never corrupts the other channel.
- Used as the fan-out stage after mux-based datapaths in the combinational-to-sequential exercise series.

Parameters:
width, 2, data word width in bits (must be >= 1)
CNT_W, 8, width of the per-channel transfer counters (only present with DEMUX_STATS_EN)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
in_data  input  width  input word
in_sel  input  1  destination: 0 = channel 0, 1 = channel 1
in_valid  input  1  input word present
in_ready  output  1  demux can accept the input word this cycle
out0_data  output  width  channel 0 word
out0_valid  output  1  channel 0 holds a word
out0_ready  input  1  channel 0 consumer accepts
out1_data  output  width  channel 1 word
out1_valid  output  1  channel 1 holds a word
out1_ready  input  1  channel 1 consumer accepts
cnt0  output  CNT_W  completed channel 0 transfers (DEMUX_STATS_EN only)
cnt1  output  CNT_W  completed channel 1 transfers (DEMUX_STATS_EN only)

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - out0_data, out1_data, out0_valid, out1_valid, cnt0 and cnt1 clear to 0.
  - Held words are discarded.
  - Release of reset is synchronous to the next clk edge. No output toggles until the first accept.
- Channel k can load when outk_valid is 0 or outk_ready is 1 (free, or draining this cycle).
- in_ready is combinational:
  - equals "channel 0 can load" when in_sel = 0;
  - equals "channel 1 can load" when in_sel = 1;
  - it does not depend on in_valid.
- Accept occurs when in_valid and in_ready are both 1. in_sel and in_data are sampled only on accept.
- On accept to channel k:
  - outk_data <= in_data and outk_valid <= 1 at the next edge (latency 1 cycle).
  - This also applies when outk_ready = 1 in the same cycle: the old word leaves and the new word loads. Back-to-back throughput is 1 word/cycle per channel.
- With no accept to channel k and outk_ready = 1: outk_valid <= 0. outk_data keeps its last value, which is don't-care.
- While outk_valid = 1 and outk_ready = 0:
  - outk_data and outk_valid hold stable;
  - input words selecting channel k stall (in_ready = 0);
  - words selecting the other channel still flow if that channel can load.
- Simultaneous events:
  - An accept on one channel and a drain on the other in the same cycle are independent.
  - At most one channel loads per cycle.
- in_valid = 0: no state change except drains.
- No combinational path from in_data to any outk_data. The only combinational input-to-output paths are out0_ready/out1_ready/in_sel -> in_ready.
- An X on in_sel while in_valid = 1 is illegal stimulus; the bench must not drive it.

Optional Feature:
- Macro: DEMUX_STATS_EN
- Defined:
  - cnt0/cnt1 ports exist.
  - cntk increments by 1 on each cycle where outk_valid and outk_ready are both 1.
  - Counting wraps from 2^CNT_W-1 to 0 with no saturation.
  - Counters are cleared only by rst_n.
- Undefined:
  - cnt0/cnt1 ports and counter logic are absent; CNT_W is unused.
  - All other behaviour is identical.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1. Inputs in_valid=0, out0_ready=out1_ready=1. Required: out0_valid=out1_valid=0, data=2'b00, in_ready=1.
- Basic steer: in_data=2'b10, in_sel=0, in_valid=1 for 1 cycle, then in_data=2'b11, in_sel=1. Required: out0_data=2'b10 with out0_valid=1 one cycle after the first accept; out1_data=2'b11 with out1_valid=1 one cycle later.
- Stall isolation: out0_ready=0, two words to channel 0 (2'b01, then 2'b10).
  - Required: the first word is held and in_ready=0 for the second.
  - A word 2'b11 with in_sel=1 is accepted and appears on channel 1 meanwhile.
  - Raising out0_ready releases 2'b01, then 2'b10 loads.
- Full-rate stream: out1_ready=1, eight consecutive words 0,1,2,3,0,1,2,3 with in_sel=1. Required: in_ready stays 1 and out1_data follows the inputs with a 1-cycle delay, no gaps.
- Async reset mid-operation: out0_valid=1 holding 2'b11, out0_ready=0. Pulse rst_n low between clock edges. Required: out0_valid=0 and out0_data=2'b00 immediately, before the next edge.
- With DEMUX_STATS_EN, CNT_W=2: five completed channel 0 handshakes and zero on channel 1. Required: cnt0=1 (wrapped) and cnt1=0.
